// File: rtl/lvds_tx_sched.sv
// Two-channel round-robin word scheduler feeding the LVDS TX serializer.
// Each presented word is frozen through one serializer frame after it is pulled.
module lvds_tx_sched #(
  parameter int unsigned BURST_MAX   = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned IDLE_FRAMES = 4
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        i_enable,
  input  logic [1:0]  i_ch_mask,
  input  logic        i_ch0_empty,
  input  logic [31:0] i_ch0_data,
  output logic        o_ch0_pull,
  input  logic        i_ch1_empty,
  input  logic [31:0] i_ch1_data,
  output logic        o_ch1_pull,
  output logic        o_fifo_empty,
  output logic [31:0] o_fifo_data,
  input  logic        i_fifo_pull,
  output logic        o_tx_state,
  output logic        o_cur_ch,
  output logic [15:0] o_ch0_count,
  output logic [15:0] o_ch1_count
);

  localparam int unsigned IDLE_LIMIT = IDLE_FRAMES * HOLD_CYCLES;
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOADED, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic          en_meta, en_sync;
  logic          rr_ptr;
  logic [BW-1:0] burst;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idle_cnt;
  logic          elig0, elig1, elig_cur, elig_oth;
  logic          grant_vld, grant_ch;

  assign elig0    = i_ch_mask[0] & ~i_ch0_empty & en_sync;
  assign elig1    = i_ch_mask[1] & ~i_ch1_empty & en_sync;
  assign elig_cur = rr_ptr ? elig1 : elig0;
  assign elig_oth = rr_ptr ? elig0 : elig1;

  assign o_ch0_pull = grant_vld & ~grant_ch;
  assign o_ch1_pull = grant_vld &  grant_ch;

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_ch  = rr_ptr;
    case (state)
      S_IDLE: begin
        if (elig0 | elig1) begin
          grant_vld = 1'b1;
          // Stay unless the other side is waiting and this burst is spent.
          if (!(elig_cur && !(elig_oth && burst >= BURST_LIM)))
            grant_ch = ~rr_ptr;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH:  state_nxt = S_LOADED;
      S_LOADED: if (i_fifo_pull) state_nxt = S_HOLD;
      S_HOLD:   if (hold_cnt == '0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state        <= S_IDLE;
      en_meta      <= 1'b0;
      en_sync      <= 1'b0;
      rr_ptr       <= 1'b0;
      burst        <= '0;
      hold_cnt     <= '0;
      idle_cnt     <= '0;
      o_fifo_empty <= 1'b1;
      o_fifo_data  <= '0;
      o_cur_ch     <= 1'b0;
      o_tx_state   <= 1'b0;
      o_ch0_count  <= '0;
      o_ch1_count  <= '0;
    end else begin
      state   <= state_nxt;
      en_meta <= i_enable;
      en_sync <= en_meta;

      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            rr_ptr     <= grant_ch;
            o_tx_state <= 1'b1;
            if (grant_ch != rr_ptr)
              burst <= BW'(1);
            else if (burst < BURST_LIM)
              burst <= burst + 1'b1;
          end
        end
        S_FETCH: begin
          o_fifo_data  <= rr_ptr ? i_ch1_data : i_ch0_data;
          o_fifo_empty <= 1'b0;
          o_cur_ch     <= rr_ptr;
        end
        S_LOADED: begin
          if (i_fifo_pull) begin
            o_fifo_empty <= 1'b1;
            hold_cnt     <= HOLD_LOAD;
            if (o_cur_ch) o_ch1_count <= o_ch1_count + 1'b1;
            else          o_ch0_count <= o_ch0_count + 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase

      // Idle timeout counts only consecutive IDLE cycles with no grant.
      if (state == S_IDLE && !grant_vld) begin
        if (idle_cnt == IDLE_LAST) o_tx_state <= 1'b0;
        else                       idle_cnt   <= idle_cnt + 1'b1;
        if (!en_sync)              o_tx_state <= 1'b0;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lvds_tx_sched.sv
// Randomised bench for lvds_tx_sched: FIFO/serializer emulation plus a
// transaction-level reference model compared on every cycle.
module tb_lvds_tx_sched;

  localparam int unsigned BM  = 8;
  localparam int unsigned HC  = 16;
  localparam int unsigned IFR = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mask = 2'b00;
  logic        e0 = 1'b1, e1 = 1'b1;
  logic [31:0] d0 = '0, d1 = '0;
  logic        p0, p1;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pull = 1'b0;
  logic        tx, cur_ch;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  lvds_tx_sched #(.BURST_MAX(BM), .HOLD_CYCLES(HC), .IDLE_FRAMES(IFR)) dut (
    .i_ddr_clk(clk), .i_rst_b(rst_b), .i_enable(enable), .i_ch_mask(mask),
    .i_ch0_empty(e0), .i_ch0_data(d0), .o_ch0_pull(p0),
    .i_ch1_empty(e1), .i_ch1_data(d1), .o_ch1_pull(p1),
    .o_fifo_empty(fifo_empty), .o_fifo_data(fifo_data), .i_fifo_pull(fifo_pull),
    .o_tx_state(tx), .o_cur_ch(cur_ch), .o_ch0_count(cnt0), .o_ch1_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO contents and serializer behaviour
  logic [31:0] q0[$], q1[$];
  int  pull_mode = 3;   // 0: pull after word seen, 1: always, 2: random, 3: never
  bit  pull0_seen = 0, pull1_seen = 0, seen_empty = 1;

  always begin
    @(posedge clk); #1;
    if (pull0_seen && q0.size() > 0) d0 = q0.pop_front();
    if (pull1_seen && q1.size() > 0) d1 = q1.pop_front();
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    case (pull_mode)
      0:       fifo_pull = !seen_empty;
      1:       fifo_pull = 1'b1;
      2:       fifo_pull = 1'($urandom_range(0, 1));
      default: fifo_pull = 1'b0;
    endcase
  end

  // Reference model state
  int          k = 0, idle_from = 0, fetch_due = -1, run_len = 0, idle_run = 0, n_pull1 = 0;
  bit          busy, present, prev_accept, prev_pull, prev_clear, m_ch, pend_ch, m_tx, last;
  bit          s1, s2, en_prev;
  logic [31:0] m_word, pend_word;
  logic [15:0] m_cnt0, m_cnt1;
  bit          glog[$];
  logic [31:0] plog[$];

  function automatic void model_reset();
    busy = 0; present = 0; prev_accept = 0; prev_pull = 0; prev_clear = 0;
    m_ch = 0; m_tx = 0; last = 0; run_len = 0; idle_run = 0;
    s1 = 0; s2 = 0; en_prev = 0; m_word = '0; m_cnt0 = '0; m_cnt1 = '0;
    fetch_due = -1; idle_from = 0;
  endfunction

  always @(negedge clk) begin : mon
    bit idle, el0, el1, g, cur_ok, oth_ok, ep0, ep1;
    k++;
    if (!rst_b) begin
      model_reset();
      chk("rst_empty", fifo_empty, 1); chk("rst_data", fifo_data, 0);
      chk("rst_pull0", p0, 0); chk("rst_pull1", p1, 0); chk("rst_tx", tx, 0);
      chk("rst_cur_ch", cur_ch, 0); chk("rst_cnt0", cnt0, 0); chk("rst_cnt1", cnt1, 0);
      pull0_seen = 0; pull1_seen = 0; seen_empty = 1;
    end else begin
      s2 = s1; s1 = en_prev; en_prev = enable;
      if (prev_accept) begin
        present = 0; busy = 0; idle_from = k + HC;
        if (m_ch) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
      end
      if (prev_pull)  m_tx = 1;
      if (prev_clear) m_tx = 0;
      if (fetch_due == k) begin
        present = 1; m_word = pend_word; m_ch = pend_ch; plog.push_back(pend_word);
      end
      chk("empty", fifo_empty, !present);
      chk("data", fifo_data, m_word);
      chk("cur_ch", cur_ch, m_ch);
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
      chk("tx_state", tx, m_tx);

      idle = !busy && (k >= idle_from);
      el0 = mask[0] && !e0 && s2;
      el1 = mask[1] && !e1 && s2;
      ep0 = 0; ep1 = 0; prev_pull = 0; prev_clear = 0;
      if (idle && (el0 || el1)) begin
        cur_ok = last ? el1 : el0;
        oth_ok = last ? el0 : el1;
        if (cur_ok && !(oth_ok && run_len >= BM)) begin
          g = last; run_len++;
        end else begin
          g = !last; last = g; run_len = 1;
        end
        if (g) ep1 = 1; else ep0 = 1;
        busy = 1; pend_ch = g; pend_word = g ? q1[0] : q0[0];
        fetch_due = k + 2; prev_pull = 1; glog.push_back(g); idle_run = 0;
      end else if (idle) begin
        idle_run++;
        if (!s2 || idle_run >= IFR * HC) prev_clear = 1;
      end else begin
        idle_run = 0;
      end
      chk("pull0", p0, ep0);
      chk("pull1", p1, ep1);
      prev_accept = fifo_pull && present;
      pull0_seen = p0; pull1_seen = p1; seen_empty = fifo_empty;
      if (p1) n_pull1++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input bit ch, input logic [31:0] w);
    if (ch) q1.push_back(w); else q0.push_back(w);
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0; enable = 1'b0; pull_mode = 3;
    q0.delete(); q1.delete(); e0 = 1'b1; e1 = 1'b1;
    cyc(3);
    rst_b = 1'b1;
    plog.delete(); glog.delete(); n_pull1 = 0;
  endtask

  task automatic wait_words(input int n, input int budget, input string nm);
    int t = 0;
    while (int'(m_cnt0) + int'(m_cnt1) < n && t < budget) begin
      cyc(1); t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s: timeout, delivered %0d required %0d", nm, int'(m_cnt0) + int'(m_cnt1), n);
    end
  endtask

  initial begin
    logic [31:0] wa, wb, wc;
    int t;

    // Single channel, three words in order
    do_reset();
    enable = 1; mask = 2'b01; pull_mode = 0;
    wa = $urandom; wb = $urandom; wc = $urandom;
    push(0, wa); push(0, wb); push(0, wc);
    wait_words(3, 300, "t1_words");
    @(negedge clk); #1;
    chk("t1_cnt0", cnt0, 16'd3);
    chk("t1_tx", tx, 1);
    chk("t1_nwords", plog.size(), 3);
    if (plog.size() == 3) begin
      chk("t1_w0", plog[0], wa); chk("t1_w1", plog[1], wb); chk("t1_w2", plog[2], wc);
    end
    chk("t1_frozen", fifo_data, wc);

    // Both channels full: 8/8/8 burst pattern
    do_reset();
    enable = 1; mask = 2'b11; pull_mode = 1;
    for (int i = 0; i < 20; i++) begin push(0, $urandom); push(1, $urandom); end
    wait_words(24, 1500, "t2_words");
    @(negedge clk); #1;
    chk("t2_cnt0", cnt0, 16'd16);
    chk("t2_cnt1", cnt1, 16'd8);
    chk("t2_grants", glog.size() >= 24, 1);
    if (glog.size() >= 24)
      for (int i = 0; i < 24; i++) chk("t2_grant_ch", glog[i], (i >= 8 && i < 16));

    // CH1 masked: never pulled; tx drops after idle timeout
    do_reset();
    enable = 1; mask = 2'b01; pull_mode = 0;
    push(0, $urandom);
    for (int i = 0; i < 4; i++) push(1, $urandom);
    wait_words(1, 200, "t3_words");
    cyc(3);
    chk("t3_tx_on", tx, 1);
    cyc(100);
    chk("t3_tx_off", tx, 0);
    chk("t3_no_ch1_pull", n_pull1, 0);
    chk("t3_cnt1", cnt1, 0);

    // Serializer pulls while nothing presented
    do_reset();
    enable = 1; mask = 2'b11; pull_mode = 1;
    cyc(40);
    chk("t4_cnt0", cnt0, 0);
    chk("t4_cnt1", cnt1, 0);
    chk("t4_no_grant", glog.size(), 0);

    // Enable dropped while a word is presented
    do_reset();
    enable = 1; mask = 2'b01; pull_mode = 3;
    wa = $urandom;
    push(0, wa); push(0, $urandom); push(0, $urandom);
    t = 0;
    while (fifo_empty && t < 60) begin cyc(1); t++; end
    chk("t5_loaded", fifo_empty, 0);
    enable = 0;
    cyc(6);
    pull_mode = 0;
    wait_words(1, 100, "t5_words");
    pull_mode = 3;
    cyc(60);
    chk("t5_cnt0", cnt0, 16'd1);
    chk("t5_tx", tx, 0);
    chk("t5_one_grant", glog.size(), 1);
    chk("t5_left", q0.size(), 2);
    if (plog.size() > 0) chk("t5_word", plog[0], wa);

    // Reset during HOLD
    do_reset();
    enable = 1; mask = 2'b11; pull_mode = 1;
    for (int i = 0; i < 4; i++) begin push(0, $urandom); push(1, $urandom); end
    wait_words(2, 200, "t6_words");
    cyc(3);
    rst_b = 1'b0;
    @(negedge clk); #1;
    chk("t6_cnt0", cnt0, 0);
    chk("t6_cnt1", cnt1, 0);
    chk("t6_empty", fifo_empty, 1);
    chk("t6_data", fifo_data, 0);
    chk("t6_tx", tx, 0);
    cyc(2);
    rst_b = 1'b1;

    // Random soak: traffic, mask and enable changes, random serializer pulls
    do_reset();
    enable = 1; mask = 2'b11; pull_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) push(0, $urandom);
      if ($urandom_range(0, 7) == 0) push(1, $urandom);
      if (i % 200 == 199) begin
        mask   = 2'($urandom_range(0, 3));
        enable = ($urandom_range(0, 4) != 0);
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
